// File: rtl/s2_pkg.sv
// Shared constants, state encoding and address helper for the stage-2 convolution scheduler.
package s2_pkg;

    localparam int N_FILT  = 4;
    localparam int OUT_DIM = 6;
    localparam int N_POS   = 36;
    localparam int N_OUT   = 144;
    localparam int ADDR_W  = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } sched_state_e;

    // Linear result-buffer address of a (filter, window) pair; at most 3*36+35 = 143.
    function automatic logic [ADDR_W-1:0] lin_addr(input logic [1:0] dir, input logic [5:0] pos);
        return ADDR_W'(dir) * ADDR_W'(N_POS) + ADDR_W'(pos);
    endfunction

endpackage

// File: rtl/s2_res_pipe.sv
// Capture pipeline between issue and result-buffer write: DEPTH stages of valid/addr/data
// that shift together unless held, with a synchronous clear.
module s2_res_pipe
    import s2_pkg::*;
#(
    parameter int DW    = 35,
    parameter int DEPTH = 1,
    parameter int AW    = ADDR_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hold_i,
    input  logic          clr_i,
    input  logic          valid_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] data_i,
    output logic          valid_o,
    output logic [AW-1:0] addr_o,
    output logic [DW-1:0] data_o,
    output logic          last_only_o
);

    logic [DEPTH-1:0]         valid_q;
    logic [DEPTH-1:0][AW-1:0] addr_q;
    logic [DEPTH-1:0][DW-1:0] data_q;
    logic [DEPTH-1:0]         upstream;

    // NOTE: the stage registers are reset (not just the valid bits) because wr_addr and
    // wr_data are driven straight from the last stage and must read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (clr_i) begin
            valid_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (!hold_i) begin
            // NOTE: non-blocking assignments let every stage read its neighbour's old
            // value, so the shift order inside this block does not matter.
            valid_q[0] <= valid_i;
            if (valid_i) begin
                addr_q[0] <= addr_i;
                data_q[0] <= data_i;
            end
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    addr_q[i] <= addr_q[i-1];
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    // Last stage holds the only outstanding entry: its acceptance empties the pipe.
    always_comb begin
        upstream             = valid_q;
        upstream[DEPTH-1]    = 1'b0;
        last_only_o          = valid_q[DEPTH-1] && (upstream == '0);
    end

    assign valid_o = valid_q[DEPTH-1];
    assign addr_o  = addr_q[DEPTH-1];
    assign data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/s2_conv_sched.sv
// Stage-2 convolution sequencer: walks 4 filters x 36 window positions, captures the
// datapath result per issue and writes it to the result buffer under back-pressure.
module s2_conv_sched
    import s2_pkg::*;
#(
    parameter int DW       = 35,
    parameter int PIPE_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 tensor_valid,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           proc_dir,
    output logic [5:0]           proc_counter,
    output logic [2:0]           win_row,
    output logic [2:0]           win_col,
    input  logic signed [DW-1:0] res_in,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic signed [DW-1:0] wr_data,
    input  logic                 wr_ready
);

    sched_state_e      state_q, state_d;
    logic [1:0]        dir_q, dir_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [2:0]        row_q, row_d;
    logic [2:0]        col_q, col_d;
    logic              advance;
    logic              issue;
    logic              pipe_clr;
    logic              last_only;
    logic [ADDR_W-1:0] issue_addr;

    // Everything moves unless the write at the pipe head is being refused.
    assign advance    = wr_ready || !wr_en;
    assign issue_addr = lin_addr(dir_q, cnt_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dir_q   <= '0;
            cnt_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        cnt_d    = cnt_q;
        row_d    = row_q;
        col_d    = col_q;
        busy     = 1'b0;
        done     = 1'b0;
        issue    = 1'b0;
        pipe_clr = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start && tensor_valid) state_d = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (advance) begin
                    issue = 1'b1;
                    if (col_q == 3'(OUT_DIM - 1)) begin
                        col_d = '0;
                        row_d = (row_q == 3'(OUT_DIM - 1)) ? 3'd0 : row_q + 3'd1;
                    end else begin
                        col_d = col_q + 3'd1;
                    end
                    if (cnt_q == 6'(N_POS - 1)) begin
                        cnt_d = '0;
                        dir_d = dir_q + 2'd1;
                        if (dir_q == 2'(N_FILT - 1)) state_d = S_DRAIN;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (last_only && wr_ready) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over start and over a stalled write.
        if (abort) begin
            state_d  = S_IDLE;
            dir_d    = '0;
            cnt_d    = '0;
            row_d    = '0;
            col_d    = '0;
            issue    = 1'b0;
            pipe_clr = 1'b1;
        end
    end

    s2_res_pipe #(
        .DW   (DW),
        .DEPTH(PIPE_LAT),
        .AW   (ADDR_W)
    ) u_res_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .hold_i     (!advance),
        .clr_i      (pipe_clr),
        .valid_i    (issue),
        .addr_i     (issue_addr),
        .data_i     (res_in),
        .valid_o    (wr_en),
        .addr_o     (wr_addr),
        .data_o     (wr_data),
        .last_only_o(last_only)
    );

    assign proc_dir     = dir_q;
    assign proc_counter = cnt_q;
    assign win_row      = row_q;
    assign win_col      = col_q;

endmodule

// File: doc/s2_conv_sched.md
# s2_conv_sched

Sequencer for the stage-2 convolution datapath. It walks the four filters and the 36 output positions of the 6x6 output plane: for each position it drives the filter select and window index, captures the datapath's ReLU result, and writes it to the stage-2 result buffer at a linear address 0..143. It owns the start/busy/done handshake towards the layer controller and honours back-pressure from the result buffer.

## Interface
Parameters:
- DW, 35, width of a datapath result word (signed, post-ReLU)
- PIPE_LAT, 1, number of capture register stages between issue and write (legal range 1..4)

Ports:
- clk  in  1  clock; the block uses one clock
- rst_n  in  1  reset, asynchronous and active-low
- start  in  1  request one full pass; sampled only in IDLE
- tensor_valid  in  1  input tensor and filters are loaded and stable; start is ignored while low
- abort  in  1  synchronous abort; returns to IDLE and produces no done
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse after the last result write is accepted
- proc_dir  out  2  filter select, 0..3
- proc_counter  out  6  linear window index, 0..35, equal to row*6+col
- win_row  out  3  window row, 0..5
- win_col  out  3  window column, 0..5
- res_in  in  DW  datapath result for the currently issued (proc_dir, proc_counter); combinational from the datapath
- wr_en  out  1  result write valid
- wr_addr  out  8  result address, proc_dir*36+proc_counter of the issuing cycle
- wr_data  out  DW  result word
- wr_ready  in  1  result buffer accepts a write this cycle

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start && tensor_valid -> RUN. proc_dir, proc_counter, win_row and win_col are all 0 on entry to RUN.
- RUN: one issue per advancing cycle. The index advances as follows:
  - col increments; at col 5 it wraps to 0 and row increments.
  - At row 5 / col 5, proc_counter wraps to 0 and proc_dir increments.
  - proc_dir 3 with index 35 is the last issue; the next state is DRAIN.
- Each issue samples res_in and its address into pipe stage 0. Stage PIPE_LAT-1 drives wr_en, wr_addr and wr_data.
- DRAIN: no new issues. The pipe empties; when the final write is accepted, the next state is DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Stall: "advance" means wr_ready=1, or no valid entry in the last pipe stage. When not advancing:
  - proc_dir, proc_counter and all pipe stages hold.
  - wr_en, wr_addr and wr_data stay stable.
- A write is accepted only when wr_en && wr_ready; each address 0..143 is written exactly once per pass.
- start while busy is ignored. abort in any state clears the pipe and the counters and goes to IDLE next cycle. abort has priority over start and over the stall.
- Arithmetic: wr_addr = proc_dir*36 + proc_counter, computed at 8 bits; it never exceeds 143. No width change on data.

## Timing
- Reset value of every output is 0: busy, done, proc_dir, proc_counter, win_row, win_col, wr_en, wr_addr, wr_data.
- Cycle 0: start sampled. Cycle 1: first issue (index 0, dir 0), busy=1.
- With no stall:
  - Issues occupy cycles 1..144.
  - Writes occupy cycles 1+PIPE_LAT .. 144+PIPE_LAT.
  - done is high in cycle 145+PIPE_LAT; busy drops in the same cycle.
- Each cycle of wr_ready=0 while wr_en=1 delays all later events by one cycle.
- Asynchronous reset mid-pass: everything returns to the reset values immediately; no done.

## Structure
- Shared package s2_pkg holds:
  - constants N_FILT=4, OUT_DIM=6, N_POS=36, N_OUT=144, ADDR_W=8
  - the state enum for IDLE/RUN/DRAIN/DONE
- Sub-module s2_res_pipe: a PIPE_LAT-deep valid/addr/data register chain with a common hold enable and a synchronous clear. The scheduler FSM and index counters stay in s2_conv_sched.

## Test plan
- Basic pass, PIPE_LAT=1, wr_ready=1, res_in=addr: start at cycle 0 -> wr_addr 0..143 in cycles 2..145, with wr_data equal to wr_addr; done pulse in cycle 146.
- Index walk: check the transitions at issue 35->36 (proc_dir 0->1, proc_counter 35->0, win_row 5->0, win_col 5->0) and at issue 6 (win_row 1, win_col 0).
- Back-pressure: wr_ready=0 for 3 cycles at the write of addr 50 -> addr 50 held stable for those 3 cycles, no address skipped or duplicated, done delayed by 3 cycles.
- Gating: start with tensor_valid=0 -> remains IDLE, busy=0; start pulsed during RUN -> no restart, still exactly 144 writes.
- Abort at issue 70 -> next cycle busy=0, wr_en=0, proc_dir=0, proc_counter=0; no done. A subsequent start runs a full clean pass.
- Async reset asserted mid-DRAIN with PIPE_LAT=4 -> all outputs 0 immediately; no write or done after rst_n deasserts.
